basys3_keypad: RTL

//  Scanning reader for a 4x4 Pmod KYPD matrix keypad; input-side counterpart of the multiplexed 7-seg driver.

---
 rtl/basys3_keypad_if.sv | 11 +
 rtl/basys3_keypad.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/basys3_keypad_if.sv
// basys3_keypad_if: CPU-side key bus between the keypad scanner (slave) and the AVR I/O bus (master).
interface basys3_keypad_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       overrun;
    logic       key_ack;

    modport slave  (output key_code, key_valid, key_down, overrun, input  key_ack);
    modport master (input  key_code, key_valid, key_down, overrun, output key_ack);
endinterface

// File: rtl/basys3_keypad.sv
// basys3_keypad: column-scanning, debounced reader for a 4x4 Pmod KYPD keypad.
// Optional build macro KEYPAD_FIFO_EN swaps the single holding register for a 4-entry key FIFO.
module basys3_keypad #(
    parameter int unsigned SCAN_DIV_BITS  = 16,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [3:0]     col_out,
    input  logic [3:0]     row_in,
    basys3_keypad_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    logic [3:0]               row_s1_q, row_s2_q;
    logic [SCAN_DIV_BITS-1:0] div_q;
    logic [1:0]               col_q;
    logic [3:0]               col_out_q;
    logic                     frame_hit_q;
    logic [3:0]               frame_code_q;
    state_t                   state_q;
    logic [3:0]               cand_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     key_down_q;

    logic             tick_c, frame_end_c, row_hit_c, hit_c, emit_c;
    logic [1:0]       row_idx_c;
    logic [3:0]       code_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Physical key position to hex legend.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_map = 4'h1;  4'b00_01: key_map = 4'h2;
            4'b00_10: key_map = 4'h3;  4'b00_11: key_map = 4'hA;
            4'b01_00: key_map = 4'h4;  4'b01_01: key_map = 4'h5;
            4'b01_10: key_map = 4'h6;  4'b01_11: key_map = 4'hB;
            4'b10_00: key_map = 4'h7;  4'b10_01: key_map = 4'h8;
            4'b10_10: key_map = 4'h9;  4'b10_11: key_map = 4'hC;
            4'b11_00: key_map = 4'h0;  4'b11_01: key_map = 4'hF;
            4'b11_10: key_map = 4'hE;  default:  key_map = 4'hD;
        endcase
    endfunction

    // Scan timing, first-hit-of-frame selection and emit decision.
    always_comb begin
        tick_c      = (div_q == {SCAN_DIV_BITS{1'b1}});
        frame_end_c = tick_c && (col_q == 2'd3);
        row_hit_c   = ~&row_s2_q;
        row_idx_c   = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2_q[r]) row_idx_c = 2'(r);
        end
        hit_c     = frame_hit_q || row_hit_c;
        code_c    = frame_hit_q ? frame_code_q : key_map(row_idx_c, col_q);
        cnt_inc_c = cnt_q + CNT_W'(1);
        emit_c    = 1'b0;
        if (frame_end_c && hit_c) begin
            case (state_q)
                IDLE:      emit_c = (DEBOUNCE_SCANS == 1);
                PRESS_CHK: emit_c = (code_c == cand_q) && (cnt_inc_c == CNT_MAX);
                default:   emit_c = 1'b0;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous row lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_in;
            row_s2_q <= row_s1_q;
        end
    end

    // Column divider/walker and per-frame first-hit capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            col_q        <= 2'd0;
            col_out_q    <= 4'b1110;
            frame_hit_q  <= 1'b0;
            frame_code_q <= 4'd0;
        end else begin
            div_q <= div_q + SCAN_DIV_BITS'(1);
            if (tick_c) begin
                col_q     <= col_q + 2'd1;
                col_out_q <= ~(4'b0001 << (col_q + 2'd1));
                if (frame_end_c) begin
                    frame_hit_q  <= 1'b0;
                    frame_code_q <= 4'd0;
                end else begin
                    frame_hit_q  <= hit_c;
                    frame_code_q <= code_c;
                end
            end
        end
    end

    // Debounce FSM, stepped once per completed frame; key_down tracks HELD/REL_CHK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cand_q     <= 4'd0;
            cnt_q      <= '0;
            key_down_q <= 1'b0;
        end else if (frame_end_c) begin
            case (state_q)
                IDLE: begin
                    if (hit_c) begin
                        cand_q <= code_c;
                        cnt_q  <= CNT_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_q    <= HELD;
                            key_down_q <= 1'b1;
                        end else begin
                            state_q <= PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (hit_c && (code_c == cand_q)) begin
                        cnt_q <= cnt_inc_c;
                        if (emit_c) begin
                            state_q    <= HELD;
                            key_down_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                HELD: begin
                    if (!hit_c) begin
                        cnt_q <= CNT_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_q    <= IDLE;
                            key_down_q <= 1'b0;
                        end else begin
                            state_q <= REL_CHK;
                        end
                    end
                end
                REL_CHK: begin
                    if (!hit_c) begin
                        cnt_q <= cnt_inc_c;
                        if (cnt_inc_c == CNT_MAX) begin
                            state_q    <= IDLE;
                            key_down_q <= 1'b0;
                            cnt_q      <= '0;
                        end
                    end else begin
                        state_q <= HELD;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    key_down_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEYPAD_FIFO_EN
    logic [3:0] fifo_q [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] fcnt_q;
    logic       overrun_q;
    logic       pop_c, full_c, push_ok_c;

    // FIFO push/pop qualification; a pop frees the slot for a same-cycle push.
    always_comb begin
        pop_c     = bus.key_ack && (fcnt_q != 3'd0);
        full_c    = (fcnt_q == 3'd4);
        push_ok_c = emit_c && (!full_c || pop_c);
    end

    // Key FIFO storage, pointers and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= 4'd0;
            wr_q      <= 2'd0;
            rd_q      <= 2'd0;
            fcnt_q    <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok_c) begin
                fifo_q[wr_q] <= code_c;
                wr_q         <= wr_q + 2'd1;
            end
            if (pop_c) rd_q <= rd_q + 2'd1;
            fcnt_q <= fcnt_q + 3'(push_ok_c) - 3'(pop_c);
            if (emit_c && full_c && !pop_c) overrun_q <= 1'b1;
            else if (pop_c)                 overrun_q <= 1'b0;
        end
    end

    assign bus.key_code  = fifo_q[rd_q];
    assign bus.key_valid = (fcnt_q != 3'd0);
    assign bus.overrun   = overrun_q;
`else
    logic [3:0] key_code_q;
    logic       key_valid_q, overrun_q;

    // Single holding register; a new key overwrites, and wins over a same-cycle ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (emit_c) begin
            key_code_q  <= code_c;
            key_valid_q <= 1'b1;
            if (key_valid_q && !bus.key_ack) overrun_q <= 1'b1;
        end else if (bus.key_ack && key_valid_q) begin
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end
    end

    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.overrun   = overrun_q;
`endif

    assign bus.key_down = key_down_q;
    assign col_out      = col_out_q;
endmodule
